// File: rtl/pfb_reload_pkg.sv
// Shared definitions for the PFB coefficient reload path: set geometry,
// coefficient width and the reload scheduler state encoding.
package pfb_reload_pkg;

  localparam int NUM_TAPS      = 4096;
  localparam int COEF_W        = 25;
  localparam int CONFIG_CYCLES = 4100;
  localparam int CNT_W         = 13;

  localparam logic [31:0] COEF_MASK = 32'((64'd1 << COEF_W) - 64'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_PAD,
    ST_DRAIN,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/pfb_coeff_reload_sched_rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred requester when
// both ask at once; an update strobe hands preference to the other side.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~served;
    end
  end

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/pfb_coeff_reload_sched.sv
// Arbitrates two coefficient-set requesters onto the single reload stream,
// forcing every forwarded set to exactly NUM_TAPS beats.
//
// state | meaning
// IDLE  | arbitrate requesters, no data movement
// XFER  | granted source passed through, counting beats
// PAD   | source ended early, zero beats up to the final tap
// DRAIN | final tap sent without source tlast, discard source to its tlast
// WAIT  | downstream config sweep cool-down
module pfb_coeff_reload_sched
  import pfb_reload_pkg::*;
(
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [31:0] s0_axis_tdata,
  input  logic        s0_axis_tlast,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  input  logic [31:0] s1_axis_tdata,
  input  logic        s1_axis_tlast,
  output logic        m_axis_reload_tvalid,
  output logic [31:0] m_axis_reload_tdata,
  output logic        m_axis_reload_tlast,
  input  logic        m_axis_reload_tready,
  output logic        busy,
  output logic        active_src,
  output logic        len_err,
  output logic        done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, wait_cnt;
  logic             src_sel;
  logic             gnt_valid, gnt_idx;
  logic             sel_valid, sel_last;
  logic [31:0]      sel_data;
  logic             last_beat, wait_done;
  logic             beat_clr, beat_inc, wait_clr, rr_update;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (sync_reset),
    .req      ({s1_axis_tvalid, s0_axis_tvalid}),
    .update   (rr_update),
    .served   (src_sel),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    sel_valid = src_sel ? s1_axis_tvalid : s0_axis_tvalid;
    sel_last  = src_sel ? s1_axis_tlast  : s0_axis_tlast;
    sel_data  = src_sel ? s1_axis_tdata  : s0_axis_tdata;
    last_beat = (beat_cnt == CNT_W'(NUM_TAPS - 1));
    wait_done = (wait_cnt == CNT_W'(CONFIG_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
      src_sel  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat_clr) begin
        beat_cnt <= '0;
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT && !wait_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ST_IDLE && gnt_valid) begin
        src_sel <= gnt_idx;
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    beat_clr             = 1'b0;
    beat_inc             = 1'b0;
    wait_clr             = 1'b0;
    rr_update            = 1'b0;
    s0_axis_tready       = 1'b0;
    s1_axis_tready       = 1'b0;
    m_axis_reload_tvalid = 1'b0;
    m_axis_reload_tdata  = '0;
    m_axis_reload_tlast  = 1'b0;
    len_err              = 1'b0;
    done                 = 1'b0;

    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_nxt = ST_XFER;
          beat_clr  = 1'b1;
        end
      end
      ST_XFER: begin
        m_axis_reload_tvalid = sel_valid;
        m_axis_reload_tdata  = sel_data & COEF_MASK;
        m_axis_reload_tlast  = last_beat;
        if (src_sel) s1_axis_tready = m_axis_reload_tready;
        else         s0_axis_tready = m_axis_reload_tready;
        if (sel_valid && m_axis_reload_tready) begin
          if (sel_last && last_beat) begin
            state_nxt = ST_WAIT;
            wait_clr  = 1'b1;
          end else if (sel_last) begin
            len_err   = 1'b1;
            beat_inc  = 1'b1;
            state_nxt = ST_PAD;
          end else if (last_beat) begin
            len_err   = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      ST_PAD: begin
        m_axis_reload_tvalid = 1'b1;
        m_axis_reload_tlast  = last_beat;
        if (m_axis_reload_tready) begin
          if (last_beat) begin
            state_nxt = ST_WAIT;
            wait_clr  = 1'b1;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (src_sel) s1_axis_tready = 1'b1;
        else         s0_axis_tready = 1'b1;
        if (sel_valid && sel_last) begin
          state_nxt = ST_WAIT;
          wait_clr  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_done) begin
          done      = 1'b1;
          rr_update = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign active_src = src_sel;

endmodule

// File: tb/tb_pfb_coeff_reload_sched.sv
// Randomized bench for the coefficient reload scheduler; expected streams come
// from a set-level model (truncate/zero-fill to NUM_TAPS, service order).
module tb_pfb_coeff_reload_sched;
  import pfb_reload_pkg::*;

  localparam logic [31:0] TB_MASK = (32'h1 << COEF_W) - 32'h1;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [31:0] s0_axis_tdata;
  logic        s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [31:0] s1_axis_tdata;
  logic        m_axis_reload_tvalid, m_axis_reload_tlast, m_axis_reload_tready;
  logic [31:0] m_axis_reload_tdata;
  logic        busy, active_src, len_err, done;

  always #5 clk = ~clk;

  pfb_coeff_reload_sched dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .s0_axis_tvalid      (s0_axis_tvalid),
    .s0_axis_tready      (s0_axis_tready),
    .s0_axis_tdata       (s0_axis_tdata),
    .s0_axis_tlast       (s0_axis_tlast),
    .s1_axis_tvalid      (s1_axis_tvalid),
    .s1_axis_tready      (s1_axis_tready),
    .s1_axis_tdata       (s1_axis_tdata),
    .s1_axis_tlast       (s1_axis_tlast),
    .m_axis_reload_tvalid(m_axis_reload_tvalid),
    .m_axis_reload_tdata (m_axis_reload_tdata),
    .m_axis_reload_tlast (m_axis_reload_tlast),
    .m_axis_reload_tready(m_axis_reload_tready),
    .busy                (busy),
    .active_src          (active_src),
    .len_err             (len_err),
    .done                (done)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] src0_q[$], src1_q[$];
  int          src_idx[2];
  int          src_vp[2];
  int          m_rp;
  logic        src_hold[2];

  logic [31:0] out_data[$];
  logic        out_last[$];
  logic        out_src[$];
  int cyc, len_err_cnt, done_cnt, done_cyc, last_cyc;
  int src_hs[2];
  int hs_after_last, mvalid_after_last, axis_viol;
  logic prev_stall, prev_last;
  logic [31:0] prev_data;
  bit seen_last;

  function automatic logic [39:0] out_vec();
    return {m_axis_reload_tvalid, m_axis_reload_tdata, m_axis_reload_tlast, busy,
            active_src, len_err, done, s0_axis_tready, s1_axis_tready};
  endfunction

  // Model: beat i of a set from source s is its coefficient if present, else zero.
  function automatic int first_bad(int s, int base, int n);
    logic [31:0] exp_d;
    int len;
    len = (s == 0) ? src0_q.size() : src1_q.size();
    for (int i = 0; i < n; i++) begin
      if (i < len) exp_d = ((s == 0) ? src0_q[i] : src1_q[i]) & TB_MASK;
      else         exp_d = 32'h0;
      if (base + i >= out_data.size()) return i;
      if (out_data[base+i] !== exp_d || out_last[base+i] !== (i == NUM_TAPS - 1) ||
          out_src[base+i] !== s[0]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    bit m_hs;
    @(negedge clk);
    if (!src_hold[0])
      s0_axis_tvalid = (src_idx[0] < src0_q.size()) && ($urandom_range(99) < src_vp[0]);
    if (s0_axis_tvalid) begin
      s0_axis_tdata = src0_q[src_idx[0]];
      s0_axis_tlast = (src_idx[0] == src0_q.size() - 1);
    end else begin
      s0_axis_tdata = $urandom;
      s0_axis_tlast = 1'b0;
    end
    if (!src_hold[1])
      s1_axis_tvalid = (src_idx[1] < src1_q.size()) && ($urandom_range(99) < src_vp[1]);
    if (s1_axis_tvalid) begin
      s1_axis_tdata = src1_q[src_idx[1]];
      s1_axis_tlast = (src_idx[1] == src1_q.size() - 1);
    end else begin
      s1_axis_tdata = $urandom;
      s1_axis_tlast = 1'b0;
    end
    m_axis_reload_tready = ($urandom_range(99) < m_rp);
    #1;
    if (prev_stall && (!m_axis_reload_tvalid || m_axis_reload_tdata !== prev_data ||
                       m_axis_reload_tlast !== prev_last)) axis_viol++;
    m_hs = m_axis_reload_tvalid && m_axis_reload_tready;
    if (m_hs) begin
      out_data.push_back(m_axis_reload_tdata);
      out_last.push_back(m_axis_reload_tlast);
      out_src.push_back(active_src);
    end else if (seen_last && m_axis_reload_tvalid) begin
      mvalid_after_last++;
    end
    if (s0_axis_tvalid && s0_axis_tready) begin
      src_idx[0]++; src_hs[0]++;
      if (seen_last) hs_after_last++;
    end
    if (s1_axis_tvalid && s1_axis_tready) begin
      src_idx[1]++; src_hs[1]++;
      if (seen_last) hs_after_last++;
    end
    src_hold[0] = s0_axis_tvalid && !s0_axis_tready;
    src_hold[1] = s1_axis_tvalid && !s1_axis_tready;
    if (m_hs && m_axis_reload_tlast) begin
      seen_last = 1'b1;
      last_cyc  = cyc;
    end
    prev_stall = m_axis_reload_tvalid && !m_axis_reload_tready;
    prev_data  = m_axis_reload_tdata;
    prev_last  = m_axis_reload_tlast;
    if (len_err) len_err_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic apply_reset();
    sync_reset = 1'b1;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    m_axis_reload_tready = 1'b0;
    src0_q.delete(); src1_q.delete();
    out_data.delete(); out_last.delete(); out_src.delete();
    for (int s = 0; s < 2; s++) begin
      src_idx[s] = 0; src_hold[s] = 1'b0; src_hs[s] = 0; src_vp[s] = 100;
    end
    m_rp = 100;
    cyc = 0; len_err_cnt = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    hs_after_last = 0; mvalid_after_last = 0; axis_viol = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; seen_last = 1'b0;
    repeat (3) @(negedge clk);
    sync_reset = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    timed_out = (done_cnt < target);
  endtask

  task automatic test_reset();
    apply_reset();
    sync_reset = 1'b1;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
    #2;
    tests_run++;
    if (out_vec() !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: outputs=%h expected=0", out_vec());
    end
    apply_reset();
    repeat (4) step();
    tests_run++;
    if (out_vec() !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: outputs=%h expected=0", out_vec());
    end
  endtask

  task automatic test_single();
    bit to;
    int bad;
    apply_reset();
    for (int i = 0; i < NUM_TAPS; i++) src0_q.push_back(32'(i));
    run_until_done(1, 12000, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL single_timeout: done_cnt=%0d expected=1", done_cnt); end
    tests_run++;
    if (out_data.size() !== NUM_TAPS) begin
      tests_failed++; $display("FAIL single_count: beats=%0d expected=%0d", out_data.size(), NUM_TAPS);
    end
    bad = first_bad(0, 0, NUM_TAPS);
    tests_run++;
    if (bad != -1) begin tests_failed++; $display("FAIL single_data: first bad beat=%0d expected none", bad); end
    tests_run++;
    if (len_err_cnt !== 0) begin tests_failed++; $display("FAIL single_len_err: pulses=%0d expected=0", len_err_cnt); end
    tests_run++;
    if (done_cyc - last_cyc !== CONFIG_CYCLES) begin
      tests_failed++; $display("FAIL single_cooldown: gap=%0d expected=%0d", done_cyc - last_cyc, CONFIG_CYCLES);
    end
    step();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: busy=%b expected=0", busy); end
  endtask

  task automatic test_arbitration();
    bit to;
    int bad0, bad1;
    apply_reset();
    for (int i = 0; i < NUM_TAPS; i++) begin
      src0_q.push_back($urandom);
      src1_q.push_back($urandom);
    end
    run_until_done(2, 20000, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL arb_timeout: done_cnt=%0d expected=2", done_cnt); end
    tests_run++;
    if (out_data.size() !== 2 * NUM_TAPS) begin
      tests_failed++; $display("FAIL arb_count: beats=%0d expected=%0d", out_data.size(), 2 * NUM_TAPS);
    end
    bad0 = first_bad(0, 0, NUM_TAPS);
    bad1 = first_bad(1, NUM_TAPS, NUM_TAPS);
    tests_run++;
    if (bad0 != -1 || bad1 != -1) begin
      tests_failed++; $display("FAIL arb_order: bad src0 beat=%0d src1 beat=%0d expected none", bad0, bad1);
    end
    tests_run++;
    if (len_err_cnt !== 0) begin tests_failed++; $display("FAIL arb_len_err: pulses=%0d expected=0", len_err_cnt); end
  endtask

  task automatic test_short();
    bit to;
    int bad;
    apply_reset();
    for (int i = 0; i < 100; i++) src1_q.push_back($urandom);
    run_until_done(1, 12000, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL short_timeout: done_cnt=%0d expected=1", done_cnt); end
    bad = first_bad(1, 0, NUM_TAPS);
    tests_run++;
    if (out_data.size() !== NUM_TAPS || bad != -1) begin
      tests_failed++; $display("FAIL short_pad: beats=%0d first bad=%0d expected %0d/none", out_data.size(), bad, NUM_TAPS);
    end
    tests_run++;
    if (len_err_cnt !== 1) begin tests_failed++; $display("FAIL short_len_err: pulses=%0d expected=1", len_err_cnt); end
    tests_run++;
    if (src_hs[1] !== 100) begin tests_failed++; $display("FAIL short_consumed: beats=%0d expected=100", src_hs[1]); end
  endtask

  task automatic test_long();
    bit to;
    int bad;
    apply_reset();
    for (int i = 0; i < NUM_TAPS + 4; i++) src0_q.push_back($urandom);
    run_until_done(1, 12000, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL long_timeout: done_cnt=%0d expected=1", done_cnt); end
    bad = first_bad(0, 0, NUM_TAPS);
    tests_run++;
    if (out_data.size() !== NUM_TAPS || bad != -1) begin
      tests_failed++; $display("FAIL long_trunc: beats=%0d first bad=%0d expected %0d/none", out_data.size(), bad, NUM_TAPS);
    end
    tests_run++;
    if (len_err_cnt !== 1) begin tests_failed++; $display("FAIL long_len_err: pulses=%0d expected=1", len_err_cnt); end
    tests_run++;
    if (hs_after_last !== 4 || src_hs[0] !== NUM_TAPS + 4) begin
      tests_failed++; $display("FAIL long_drain: drained=%0d total=%0d expected 4/%0d", hs_after_last, src_hs[0], NUM_TAPS + 4);
    end
    tests_run++;
    if (mvalid_after_last !== 0) begin
      tests_failed++; $display("FAIL long_drain_quiet: m_tvalid cycles=%0d expected=0", mvalid_after_last);
    end
  endtask

  task automatic test_stall();
    bit to;
    int bad;
    apply_reset();
    for (int i = 0; i < NUM_TAPS; i++) src1_q.push_back($urandom);
    src_vp[1] = 70;
    m_rp = 60;
    run_until_done(1, 25000, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL stall_timeout: done_cnt=%0d expected=1", done_cnt); end
    bad = first_bad(1, 0, NUM_TAPS);
    tests_run++;
    if (out_data.size() !== NUM_TAPS || bad != -1) begin
      tests_failed++; $display("FAIL stall_stream: beats=%0d first bad=%0d expected %0d/none", out_data.size(), bad, NUM_TAPS);
    end
    tests_run++;
    if (axis_viol !== 0) begin tests_failed++; $display("FAIL stall_axis_hold: violations=%0d expected=0", axis_viol); end
    tests_run++;
    if (len_err_cnt !== 0) begin tests_failed++; $display("FAIL stall_len_err: pulses=%0d expected=0", len_err_cnt); end
  endtask

  task automatic test_mid_reset();
    int n, bad;
    apply_reset();
    for (int i = 0; i < NUM_TAPS; i++) src0_q.push_back($urandom);
    n = 0;
    while (out_data.size() < 2000 && n < 3000) begin step(); n++; end
    tests_run++;
    if (out_data.size() !== 2000) begin
      tests_failed++; $display("FAIL midrst_progress: beats=%0d expected=2000", out_data.size());
    end
    sync_reset = 1'b1;
    #1;
    tests_run++;
    if (out_vec() !== 40'h0) begin
      tests_failed++; $display("FAIL midrst_outputs: outputs=%h expected=0", out_vec());
    end
    apply_reset();
    for (int i = 0; i < NUM_TAPS; i++) begin
      src0_q.push_back($urandom);
      src1_q.push_back($urandom);
    end
    n = 0;
    while (out_data.size() < 16 && n < 200) begin step(); n++; end
    bad = first_bad(0, 0, 16);
    tests_run++;
    if (bad != -1) begin tests_failed++; $display("FAIL midrst_restart: first bad beat=%0d expected none", bad); end
  endtask

  initial begin
    sync_reset = 1'b1;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    m_axis_reload_tready = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_short();
    test_long();
    test_stall();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
